// File: rtl/hamming_pkg.sv
// Shared Hamming SECDED helpers: check-bit count, position mapping and error classes.
package hamming_pkg;

   typedef enum logic [1:0] {ERR_NONE, ERR_SINGLE, ERR_DOUBLE} err_class_e;

   localparam int MAX_POS = 128;

   // Smallest r with 2^r >= data_w + r + 1 (descending scan keeps the smallest hit).
   function automatic int parity_w(input int data_w);
      int r;
      r = 0;
      for (int i = 7; i >= 1; i--) begin
         if ((1 << i) >= data_w + i + 1) r = i;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int pos);
      return (pos != 0) && ((pos & (pos - 1)) == 0);
   endfunction

   function automatic int data_pos(input int i);
      int cnt;
      int res;
      cnt = 0;
      res = 0;
      for (int k = 1; k < MAX_POS; k++) begin
         if (!is_pow2(k)) begin
            if (cnt == i && res == 0) res = k;
            cnt++;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for a SECDED codeword.
module hamming_syndrome
   import hamming_pkg::*;
#(
   parameter int    DATA_W   = 8,
   localparam int   PARITY_W = parity_w(DATA_W),
   localparam int   N        = DATA_W + PARITY_W,
   localparam int   CW_W     = N + 1
) (
   input  logic [CW_W-1:0]     cw_i,
   output logic [PARITY_W-1:0] syn_o,
   output logic                par_o
);

   always_comb begin
      syn_o = '0;
      for (int k = 1; k <= N; k++) begin
         if (cw_i[k]) syn_o = syn_o ^ PARITY_W'(k);
      end
   end

   assign par_o = ^cw_i;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready streaming.
// Define HAMMING_DEC_CNT_EN to build the saturating corrected/uncorrectable counters.
module hamming_secded_decoder
   import hamming_pkg::*;
#(
   parameter int    DATA_W   = 8,
   parameter int    CNT_W    = 16,
   localparam int   PARITY_W = parity_w(DATA_W),
   localparam int   CW_W     = DATA_W + PARITY_W + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CW_W-1:0]     cw_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   data_out,
   output logic                err_single,
   output logic                err_double,
   output logic [PARITY_W-1:0] err_pos,
   input  logic                cnt_clr,
   output logic [CNT_W-1:0]    corr_cnt,
   output logic [CNT_W-1:0]    uncorr_cnt
);

   localparam int N = DATA_W + PARITY_W;

   logic                s1_valid_q;
   logic [CW_W-1:0]     s1_cw_q;
   logic [PARITY_W-1:0] s1_syn;
   logic                s1_par;
   err_class_e          cls;
   logic [CW_W-1:0]     corr_cw;
   logic [DATA_W-1:0]   raw_data, cor_data, data_d;
   logic                s2_ready;
   logic                out_valid_q, err_single_q, err_double_q;
   logic [DATA_W-1:0]   data_q;
   logic [PARITY_W-1:0] err_pos_q;

   // A word moves on valid && ready; a stage may load when it is empty or its
   // contents leave in the same cycle, so ready flows back combinationally.
   assign s2_ready = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_cw_q    <= '0;
      end else if (in_ready) begin
         s1_valid_q <= in_valid;
         if (in_valid) s1_cw_q <= cw_in;
      end
   end

   hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
      .cw_i  (s1_cw_q),
      .syn_o (s1_syn),
      .par_o (s1_par)
   );

   // Odd parity with a syndrome beyond the last position cannot be a single flip.
   always_comb begin
      cls = ERR_NONE;
      if (s1_par) cls = (int'(s1_syn) > N) ? ERR_DOUBLE : ERR_SINGLE;
      else if (s1_syn != '0) cls = ERR_DOUBLE;
   end

   assign corr_cw = s1_cw_q ^ (CW_W'(1) << s1_syn);

   for (genvar i = 0; i < DATA_W; i++) begin : g_data
      localparam int P = data_pos(i);
      assign raw_data[i] = s1_cw_q[P];
      assign cor_data[i] = corr_cw[P];
   end

   assign data_d = (cls == ERR_SINGLE) ? cor_data : raw_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         data_q       <= '0;
         err_single_q <= 1'b0;
         err_double_q <= 1'b0;
         err_pos_q    <= '0;
      end else if (s2_ready) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            data_q       <= data_d;
            err_single_q <= (cls == ERR_SINGLE);
            err_double_q <= (cls == ERR_DOUBLE);
            err_pos_q    <= s1_syn;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign data_out   = data_q;
   assign err_single = err_single_q;
   assign err_double = err_double_q;
   assign err_pos    = err_pos_q;

`ifdef HAMMING_DEC_CNT_EN
   logic             out_hs;
   logic [CNT_W-1:0] corr_cnt_q, uncorr_cnt_q;

   assign out_hs = out_valid_q && out_ready;

   // Clear takes priority over a same-cycle increment; both counters stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else if (cnt_clr) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else if (out_hs) begin
         if (err_single_q && corr_cnt_q != '1)   corr_cnt_q   <= corr_cnt_q + 1'b1;
         if (err_double_q && uncorr_cnt_q != '1) uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
      end
   end

   assign corr_cnt   = corr_cnt_q;
   assign uncorr_cnt = uncorr_cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign corr_cnt       = '0;
   assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed scoreboard bench for hamming_secded_decoder (DATA_W=8, CNT_W=2).
module tb_hamming_secded_decoder;

   localparam int CW_W  = 13;
   localparam int EXP_W = 14;
`ifdef HAMMING_DEC_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [CW_W-1:0]  cw_in = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [7:0]       data_out;
   logic             err_single, err_double;
   logic [3:0]       err_pos;
   logic             cnt_clr = 1'b0;
   logic [1:0]       corr_cnt, uncorr_cnt;

   int checks = 0;
   int failures = 0;
   int acc_cnt = 0;
   logic [EXP_W-1:0] exp_q[$];
   logic [EXP_W-1:0] mon_exp;

   logic [7:0]       v_data[7];
   logic [CW_W-1:0]  v_flip[7];
   logic [EXP_W-1:0] v_exp[7];

   always #5 clk = ~clk;

   hamming_secded_decoder #(.DATA_W(8), .CNT_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .cw_in      (cw_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .data_out   (data_out),
      .err_single (err_single),
      .err_double (err_double),
      .err_pos    (err_pos),
      .cnt_clr    (cnt_clr),
      .corr_cnt   (corr_cnt),
      .uncorr_cnt (uncorr_cnt)
   );

   function automatic logic [CW_W-1:0] encode(input logic [7:0] d);
      int dpos[8];
      logic [CW_W-1:0] cw;
      logic p;
      dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
      cw = '0;
      for (int i = 0; i < 8; i++) cw[dpos[i]] = d[i];
      for (int j = 0; j < 4; j++) begin
         p = 1'b0;
         for (int k = 1; k < CW_W; k++) if ((k & (1 << j)) != 0) p = p ^ cw[k];
         cw[1 << j] = p;
      end
      cw[0] = ^cw[CW_W-1:1];
      return cw;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Called at posedge+2; returns at posedge+2 just after the handshake edge.
   task automatic send(input logic [CW_W-1:0] cw, input logic [EXP_W-1:0] exp);
      bit done;
      done = 1'b0;
      in_valid = 1'b1;
      cw_in = cw;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
      end
      if (done) begin
         exp_q.push_back(exp);
         acc_cnt++;
      end else begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready stayed 0 for cw 0x%0h", cw);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_drain: %0d words outstanding, expected 0", name, exp_q.size());
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output: data 0x%0h with empty expected queue", data_out);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({data_out, err_single, err_double, err_pos} !== mon_exp) begin
               failures++;
               $display("FAIL output: got data=0x%0h s=%0b d=%0b pos=%0d expected data=0x%0h s=%0b d=%0b pos=%0d",
                        data_out, err_single, err_double, err_pos,
                        mon_exp[13:6], mon_exp[5], mon_exp[4], mon_exp[3:0]);
            end
         end
      end
   end

   initial begin
      v_data = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'hFF, 8'h5A};
      v_flip = '{13'h0028, 13'h0112, 13'h0001, 13'h0000, 13'h1000, 13'h0004, 13'h0600};
      v_exp  = '{{8'h03, 1'b0, 1'b1, 4'd6},
                 {8'h00, 1'b0, 1'b1, 4'd13},
                 {8'h00, 1'b1, 1'b0, 4'd0},
                 {8'hA5, 1'b0, 1'b0, 4'd0},
                 {8'hA5, 1'b1, 1'b0, 4'd12},
                 {8'hFF, 1'b1, 1'b0, 4'd2},
                 {8'h6A, 1'b0, 1'b1, 4'd3}};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_flags", {err_single, err_double}, 0);
      chk("rst_err_pos", err_pos, 0);
      chk("rst_counters", {corr_cnt, uncorr_cnt}, 0);
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();

      // single data-bit error and two-cycle latency
      send(encode(8'h00) ^ 13'h0008, {8'h00, 1'b1, 1'b0, 4'd3});
      @(negedge clk);
      chk("latency_cycle1", out_valid, 0);
      @(negedge clk);
      chk("latency_cycle2", out_valid, 1);
      step();

      // classification vectors streamed back to back
      for (int i = 0; i < 7; i++) send(encode(v_data[i]) ^ v_flip[i], v_exp[i]);
      wait_drain("vectors");
      chk("vec_corr_cnt", corr_cnt, CNT_EN ? 3 : 0);
      chk("vec_uncorr_cnt", uncorr_cnt, CNT_EN ? 3 : 0);
      step();

      // clear, then saturate the corrected counter
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      @(negedge clk);
      chk("clr_counters", {corr_cnt, uncorr_cnt}, 0);
      step();
      for (int i = 0; i < 5; i++) send(encode(8'h00) ^ 13'h0008, {8'h00, 1'b1, 1'b0, 4'd3});
      wait_drain("sat");
      chk("sat_corr_cnt", corr_cnt, CNT_EN ? 3 : 0);
      chk("sat_uncorr_cnt", uncorr_cnt, 0);
      step();

      // clear coinciding with a counted handshake
      out_ready = 1'b0;
      send(encode(8'h3C) ^ 13'h0020, {8'h3C, 1'b1, 1'b0, 4'd5});
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      step();
      out_ready = 1'b1;
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      @(negedge clk);
      chk("clr_wins_corr", corr_cnt, 0);
      chk("clr_wins_uncorr", uncorr_cnt, 0);
      step();

      // backpressure: two words buffered, then in_ready drops
      out_ready = 1'b0;
      acc_cnt = 0;
      fork
         begin
            send(encode(8'h11), {8'h11, 1'b0, 1'b0, 4'd0});
            send(encode(8'h22), {8'h22, 1'b0, 1'b0, 4'd0});
            send(encode(8'h33), {8'h33, 1'b0, 1'b0, 4'd0});
            send(encode(8'h44), {8'h44, 1'b0, 1'b0, 4'd0});
         end
         begin
            repeat (6) @(negedge clk);
            chk("bp_accepts", acc_cnt, 2);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_data_hold", data_out, 8'h11);
            step();
            out_ready = 1'b1;
         end
      join
      wait_drain("bp");
      step();

      // reset with two words in flight
      send(encode(8'h5A), {8'h5A, 1'b0, 1'b0, 4'd0});
      send(encode(8'h96) ^ 13'h0800, {8'h96, 1'b1, 1'b0, 4'd11});
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_counters", {corr_cnt, uncorr_cnt}, 0);
      step();
      rst_n = 1'b1;
      step();
      send(encode(8'hC3) ^ 13'h0040, {8'hC3, 1'b1, 1'b0, 4'd6});
      wait_drain("post_rst");
      chk("post_rst_corr_cnt", corr_cnt, CNT_EN ? 1 : 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hamming_secded_decoder.md
# hamming_secded_decoder

Parametrised, pipelined Hamming SECDED (single-error-correct, double-error-detect) decoder. It accepts a codeword of DATA_W data bits, PARITY_W Hamming check bits and one overall-parity bit over a valid/ready stream. It returns corrected data with an error classification. It replaces fixed 8-bit syndrome-to-mask lookup decoding in the memory and bus read paths, and adds double-error detection, backpressure and saturating error counters.

## Interface
Parameters:
- DATA_W, 8: data bits per word, 4..64.
- PARITY_W, derived: smallest r with 2^r >= DATA_W + r + 1. It is 4 for DATA_W=8. Not overridable.
- CW_W, derived: DATA_W + PARITY_W + 1.
- CNT_W, 16: width of each error counter.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous reset, active-low.
- in_valid, in, 1: cw_in is valid.
- in_ready, out, 1: the decoder accepts cw_in this cycle.
- cw_in, in, CW_W: codeword. Bit 0 is overall parity. Bit k (1..N, N=DATA_W+PARITY_W) is Hamming position k. Check bits sit at powers of two; data bits fill the remaining positions, data bit 0 at the lowest.
- out_valid, out, 1: outputs are valid.
- out_ready, in, 1: the consumer accepts the outputs.
- data_out, out, DATA_W: corrected data, or raw data if uncorrectable.
- err_single, out, 1: a single error was corrected.
- err_double, out, 1: the error is uncorrectable.
- err_pos, out, PARITY_W: raw syndrome.
- cnt_clr, in, 1: synchronous clear of both counters.
- corr_cnt, out, CNT_W: count of delivered words with err_single.
- uncorr_cnt, out, CNT_W: count of delivered words with err_double.

## Operation
Two-stage pipeline, each stage with its own valid bit.
- Stage 1 registers cw_in.
- Stage 1 computes the syndrome s (XOR of all set positions k) and the overall parity p (XOR of all CW_W bits).
- Stage 2 registers s and p, classifies the word, applies correction and drives the outputs.

Classification:
- s=0, p=0: no error. Data is passed through and both flags are 0.
- s≠0, p=1, s≤N: single error. Bit s is flipped and err_single=1. Data changes only if s is a data position.
- s=0, p=1: error in the overall-parity bit. err_single=1 and data is unchanged.
- s≠0, p=0: double error. err_double=1 and raw data is passed out.
- s>N, p=1: invalid position. err_double=1 and raw data is passed out.

err_single and err_double are never both 1.

Counters:
- Each counter increments once per output handshake (out_valid && out_ready) that carries its flag.
- Counters saturate at 2^CNT_W−1.
- When cnt_clr coincides with an increment, cnt_clr wins and the counter becomes 0.

## Timing
- Reset (asynchronous, rst_n=0): both valid bits, out_valid, data_out, err flags, err_pos and counters go to 0. In-flight words are discarded and not counted.
- Input handshake: cw_in transfers on in_valid && in_ready.
- Ready chain (combinational): s2_ready = !out_valid || out_ready and in_ready = !s1_valid || s2_ready.
- Latency: 2 cycles from input handshake to out_valid. Throughput is one word per cycle when out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, all outputs hold stable. Up to 2 words are buffered, then in_ready goes low. Order is always preserved.
- out_valid does not depend combinationally on in_valid.
- Counter outputs update the cycle after the handshake.

## Configuration
- HAMMING_DEC_CNT_EN defined: corr_cnt and uncorr_cnt and their saturation logic are built, and cnt_clr is honoured.
- HAMMING_DEC_CNT_EN undefined: no counter registers are built. corr_cnt and uncorr_cnt are tied to 0 and cnt_clr is ignored. Ports are unchanged.

## Structure
- Package hamming_pkg holds:
  - function parity_w(data_w);
  - function is_pow2(pos);
  - function data_pos(i), which maps data index to Hamming position;
  - typedef enum err_class_e {ERR_NONE, ERR_SINGLE, ERR_DOUBLE}.
- One combinational sub-module, hamming_syndrome, computes s and p from a codeword. It is shared with the future encoder's self-check.

## Test plan
- Single data-bit error, DATA_W=8, all-zero codeword:
  - Stimulus: flip position 3.
  - Response: data_out=0x00, err_single=1, err_pos=3, 2 cycles after the handshake.
- Double error:
  - Stimulus: flip positions 3 and 5.
  - Response: err_double=1, err_pos=6, data_out=0x03 (raw), err_single=0.
- Invalid position:
  - Stimulus: flip positions 1, 4 and 8 (s=13, p=1).
  - Response: err_double=1.
  - Stimulus: flip bit 0 only.
  - Response: err_single=1, data unchanged.
- Backpressure:
  - Stimulus: stream 4 clean words 0x11, 0x22, 0x33, 0x44 with out_ready=0 for 5 cycles.
  - Response: in_ready low after 2 accepts, data_out holds 0x11. All 4 words are delivered in order after out_ready=1.
- Counters, CNT_W=2:
  - Stimulus: 5 single-error words.
  - Response: corr_cnt=3 (saturated).
  - Stimulus: cnt_clr together with a further error word.
  - Response: corr_cnt=0.
  - Without HAMMING_DEC_CNT_EN: both counters stay 0.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 with 2 words in flight.
  - Response: out_valid=0 immediately, counters 0, and the first output after release is the next accepted word.
